// File: rtl/scan_loader.sv
// Byte-wide loader for a serial scan chain: each accepted byte is shifted in LSB
// first while the displaced chain bits are reassembled into byte_out.
module scan_loader #(
    parameter int CHAIN_LEN = 272,
    parameter int CNT_WIDTH = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       scan_enable,
    output logic       scan_in,
    input  logic       chain_out,
    output logic [7:0] byte_out,
    output logic       byte_out_valid,
    output logic       busy,
    output logic       done,
    output logic       cpu_halt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_BIT = CNT_WIDTH'(CHAIN_LEN - 1);

    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] bit_cnt;
    logic [2:0]           bit_idx;
    logic [7:0]           shift_buf;
    logic [7:0]           cap_buf;
    logic                 last_of_byte;

    // Chain bits arrive LSB first, so each new sample enters at the top and
    // the first sample of a byte ends up in bit 0 after eight shifts.
    function automatic logic [7:0] capture_bit(input logic [7:0] cur, input logic b);
        return {b, cur[7:1]};
    endfunction

    assign last_of_byte = (bit_idx == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        byte_ready  = 1'b0;
        scan_enable = 1'b0;
        scan_in     = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                byte_ready = 1'b1;
                if (byte_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                scan_enable = 1'b1;
                scan_in     = shift_buf[0];
                if (last_of_byte) begin
                    state_nxt = (bit_cnt == LAST_BIT) ? DONE : WAIT;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        cpu_halt = busy;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt        <= '0;
            bit_idx        <= '0;
            shift_buf      <= '0;
            cap_buf        <= '0;
            byte_out       <= '0;
            byte_out_valid <= 1'b0;
        end else begin
            byte_out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bit_cnt <= '0;
                        bit_idx <= '0;
                    end
                end
                WAIT: begin
                    if (byte_valid) begin
                        shift_buf <= byte_in;
                    end
                end
                SHIFT: begin
                    shift_buf <= {1'b0, shift_buf[7:1]};
                    cap_buf   <= capture_bit(cap_buf, chain_out);
                    bit_cnt   <= bit_cnt + CNT_WIDTH'(1);
                    bit_idx   <= bit_idx + 3'd1;
                    // Publish the completed byte including the sample taken this cycle.
                    if (last_of_byte) begin
                        byte_out       <= capture_bit(cap_buf, chain_out);
                        byte_out_valid <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scan_loader.sv
// Bench for scan_loader: a loopback scan chain surrounds the DUT and each load
// is checked against byte-level expectations taken from the chain contents.
module tb_scan_loader;

    localparam int CHAIN_LEN = 272;
    localparam int CNT_WIDTH = 9;
    localparam int NBYTES    = CHAIN_LEN / 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;
    logic       scan_enable;
    logic       scan_in;
    logic       chain_out;
    logic [7:0] byte_out;
    logic       byte_out_valid;
    logic       busy;
    logic       done;
    logic       cpu_halt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    scan_loader #(
        .CHAIN_LEN(CHAIN_LEN),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .scan_enable   (scan_enable),
        .scan_in       (scan_in),
        .chain_out     (chain_out),
        .byte_out      (byte_out),
        .byte_out_valid(byte_out_valid),
        .busy          (busy),
        .done          (done),
        .cpu_halt      (cpu_halt)
    );

    // Loopback memory chain: oldest bit drives chain_out, scan_in enters at the far end.
    logic [CHAIN_LEN-1:0] chain;
    logic [CHAIN_LEN-1:0] chain_seed;
    logic                 chain_load;
    assign chain_out = chain[0];

    always @(posedge clk) begin
        if (chain_load) chain <= chain_seed;
        else if (scan_enable) chain <= {scan_in, chain[CHAIN_LEN-1:1]};
    end

    int   cyc = 0;
    int   sen_cnt = 0;
    int   accept_cnt = 0;
    int   strobe_cnt = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   busy_low = 0;
    int   viol = 0;
    logic in_load = 1'b0;
    bit   sin_q[$];
    logic [7:0] out_q[$];

    always @(posedge clk) begin
        cyc++;
        if (scan_enable) begin
            sen_cnt++;
            sin_q.push_back(scan_in);
        end
        if (byte_valid && byte_ready) accept_cnt++;
    end

    always @(negedge clk) begin
        if (byte_out_valid) begin
            strobe_cnt++;
            out_q.push_back(byte_out);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (!scan_enable && scan_in) viol++;
        if (cpu_halt !== busy) viol++;
        if (byte_ready && scan_enable) viol++;
        if (done && !busy) viol++;
        if (in_load && !busy) busy_low++;
    end

    logic [7:0] cur_bytes [NBYTES];
    logic [7:0] prev_bytes[NBYTES];
    bit         prev_ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: byte_valid held high; 1: random idle gaps; 2: byte 3 withheld 5 cycles in WAIT
    task automatic do_load(input int mode, input bit pulse_start, input int abort_at,
                           input bit check_loop);
        int b_acc, b_sen, b_str, b_done, start_cyc, guard, s0, nbad;
        bit pulsed, aborted;
        logic [CHAIN_LEN-1:0] snap;
        logic [7:0] rebuilt;

        b_acc = accept_cnt; b_sen = sen_cnt; b_str = strobe_cnt; b_done = done_cnt;
        busy_low = 0; pulsed = 0; aborted = 0;
        out_q.delete();
        sin_q.delete();
        snap = chain;
        byte_in = cur_bytes[0];
        byte_valid = (mode == 0);
        start = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
        in_load = 1'b1;

        for (int j = 0; j < NBYTES && !aborted; j++) begin
            byte_in = cur_bytes[j];
            if (mode == 1) begin
                byte_valid = 1'b0;
                repeat ($urandom_range(0, 12)) tick();
            end
            if (mode == 2 && j == 3) begin
                byte_valid = 1'b0;
                guard = 0;
                while (!byte_ready && guard < 30) begin tick(); guard++; end
                chk("withhold_reach_wait", {31'd0, byte_ready}, 32'd1);
                s0 = sen_cnt;
                for (int w = 0; w < 5; w++) begin
                    tick();
                    chk("withhold_ready", {31'd0, byte_ready}, 32'd1);
                    chk("withhold_no_scan", {31'd0, scan_enable}, 32'd0);
                end
                chk("withhold_bitcount", sen_cnt, s0);
            end
            byte_valid = 1'b1;
            s0 = accept_cnt;
            guard = 0;
            while (accept_cnt == s0 && guard < 100 && !aborted) begin
                start = 1'b0;
                if (pulse_start && !pulsed && scan_enable) begin
                    start = 1'b1;
                    pulsed = 1'b1;
                end
                if (abort_at >= 0 && sen_cnt == abort_at && scan_enable) begin
                    rst = 1'b1;
                    in_load = 1'b0;
                    #1;
                    chk("abort_scan_enable", {31'd0, scan_enable}, 32'd0);
                    chk("abort_scan_in", {31'd0, scan_in}, 32'd0);
                    chk("abort_busy", {31'd0, busy}, 32'd0);
                    chk("abort_cpu_halt", {31'd0, cpu_halt}, 32'd0);
                    chk("abort_ready", {31'd0, byte_ready}, 32'd0);
                    chk("abort_byte_out", {24'd0, byte_out}, 32'd0);
                    chk("abort_out_valid", {31'd0, byte_out_valid}, 32'd0);
                    s0 = sen_cnt;
                    tick();
                    tick();
                    chk("abort_no_more_scan", sen_cnt, s0);
                    rst = 1'b0;
                    byte_valid = 1'b0;
                    aborted = 1'b1;
                end else begin
                    tick();
                    guard++;
                end
            end
            if (!aborted) chk("accept_in_time", {31'd0, accept_cnt != s0}, 32'd1);
        end

        if (aborted) begin
            start = 1'b0;
            tick();
            chk("abort_idle_busy", {31'd0, busy}, 32'd0);
            prev_ok = 1'b0;
            return;
        end

        byte_valid = 1'b0;
        start = 1'b0;
        guard = 0;
        while (done_cnt == b_done && guard < 50) begin tick(); guard++; end
        in_load = 1'b0;
        repeat (3) tick();

        chk("done_pulses", done_cnt - b_done, 1);
        chk("bytes_accepted", accept_cnt - b_acc, NBYTES);
        chk("scan_cycles", sen_cnt - b_sen, CHAIN_LEN);
        chk("out_strobes", strobe_cnt - b_str, NBYTES);
        chk("busy_throughout", busy_low, 0);
        if (mode == 0) chk("done_cycle", done_cyc - start_cyc, 1 + NBYTES * 9);

        nbad = 0;
        for (int j = 0; j < NBYTES && j < out_q.size(); j++) begin
            if (out_q[j] !== snap[8*j +: 8]) nbad++;
            if (check_loop && prev_ok && out_q[j] !== prev_bytes[j]) nbad++;
        end
        chk("readback_bytes_bad", nbad, 0);

        nbad = 0;
        for (int j = 0; j < NBYTES && 8*j + 7 < sin_q.size(); j++) begin
            for (int k = 0; k < 8; k++) rebuilt[k] = sin_q[8*j + k];
            if (rebuilt !== cur_bytes[j]) nbad++;
        end
        chk("scan_in_bytes_bad", nbad, 0);

        for (int j = 0; j < NBYTES; j++) prev_bytes[j] = cur_bytes[j];
        prev_ok = 1'b1;
    endtask

    bit exp_a5[8];

    initial begin
        exp_a5 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        prev_ok = 1'b0;
        rst = 1'b1;
        start = 1'b0;
        byte_valid = 1'b0;
        byte_in = 8'h00;
        for (int i = 0; i < CHAIN_LEN; i++) chain_seed[i] = 1'($urandom_range(0, 1));
        chain_load = 1'b1;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cpu_halt", {31'd0, cpu_halt}, 32'd0);
        chk("rst_scan_enable", {31'd0, scan_enable}, 32'd0);
        chk("rst_scan_in", {31'd0, scan_in}, 32'd0);
        chk("rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_byte_out", {24'd0, byte_out}, 32'd0);
        chk("rst_out_valid", {31'd0, byte_out_valid}, 32'd0);
        chain_load = 1'b0;
        rst = 1'b0;
        tick();
        chk("idle_after_rst", {31'd0, busy}, 32'd0);

        // Full load with incrementing bytes and byte_valid always high.
        for (int j = 0; j < NBYTES; j++) cur_bytes[j] = 8'(j);
        do_load(0, 1'b0, -1, 1'b0);

        // Random bytes with gaps, first byte 0xA5; readback must be the previous load.
        for (int j = 0; j < NBYTES; j++) cur_bytes[j] = 8'($urandom);
        cur_bytes[0] = 8'hA5;
        do_load(1, 1'b0, -1, 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk("a5_scan_in_bit", {31'd0, sin_q[k]}, {31'd0, exp_a5[k]});
        end

        // Withheld byte plus a stray start during SHIFT.
        for (int j = 0; j < NBYTES; j++) cur_bytes[j] = 8'($urandom);
        do_load(2, 1'b1, -1, 1'b1);

        // Reset on the third SHIFT cycle of byte 5.
        for (int j = 0; j < NBYTES; j++) cur_bytes[j] = 8'($urandom);
        do_load(0, 1'b0, 5 * 8 + 2, 1'b0);

        // Full load after the abort.
        for (int j = 0; j < NBYTES; j++) cur_bytes[j] = 8'($urandom);
        do_load(0, 1'b0, -1, 1'b0);

        chk("output_invariants", viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
